// File: rtl/rv32_instr_encoder_if.sv
// Request/response bundle for the RV32I instruction encoder.
// The encoder takes the slave modport; the request producer takes master.
interface rv32_instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_last;
  logic        err;

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_last, err
  );

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_last, err
  );
endinterface

// File: rtl/rv32_instr_encoder.sv
// Streaming RV32I instruction encoder with LI -> LUI+ADDI expansion.
// One registered output word slot plus one pending word for the second half of LI.
module rv32_instr_encoder (
  input logic clk,
  input logic rst,
  rv32_instr_encoder_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] EMIT1 = 2'd1;
  localparam logic [1:0] EMIT2 = 2'd2;

  localparam logic [3:0] FMT_R   = 4'd0;
  localparam logic [3:0] FMT_I   = 4'd1;
  localparam logic [3:0] FMT_SH  = 4'd2;
  localparam logic [3:0] FMT_S   = 4'd3;
  localparam logic [3:0] FMT_B   = 4'd4;
  localparam logic [3:0] FMT_U   = 4'd5;
  localparam logic [3:0] FMT_J   = 4'd6;
  localparam logic [3:0] FMT_LI  = 4'd7;
  localparam logic [3:0] FMT_NOP = 4'd8;
  localparam logic [3:0] FMT_BAD = 4'd9;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  logic [1:0]  state;
  logic [31:0] pend_instr;
  logic        out_valid_q;
  logic        out_last_q;
  logic [31:0] out_instr_q;
  logic        err_q;

  logic [3:0]  fmt;
  logic [2:0]  f3;
  logic        alt;
  logic [6:0]  opc;
  logic [31:0] imm;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        fits12;
  logic        fits_sh;
  logic        fits_b;
  logic        fits_j;
  logic [19:0] li_hi;
  logic [31:0] word0;
  logic [31:0] word1;
  logic        two_words;
  logic        reject;
  logic        fire;
  logic        accept;

  assign imm = bus.in_imm;
  assign rd  = bus.in_rd;
  assign rs1 = bus.in_rs1;
  assign rs2 = bus.in_rs2;

  assign fits12  = (imm[31:11] == '0) || (imm[31:11] == '1);
  assign fits_sh = (imm[31:5] == '0);
  assign fits_b  = !imm[0] && ((imm[31:12] == '0) || (imm[31:12] == '1));
  assign fits_j  = !imm[0] && ((imm[31:20] == '0) || (imm[31:20] == '1));
  // (imm + 0x800) >> 12 without a full 32-bit add: the carry into bit 12 is imm[11]
  assign li_hi   = imm[31:12] + {19'd0, imm[11]};

  always_comb begin
    fmt = FMT_BAD;
    f3  = 3'd0;
    alt = 1'b0;
    opc = OPC_OP;
    case (bus.in_op)
      6'd0:  begin fmt = FMT_R; f3 = 3'd0; end
      6'd1:  begin fmt = FMT_R; f3 = 3'd0; alt = 1'b1; end
      6'd2:  begin fmt = FMT_R; f3 = 3'd1; end
      6'd3:  begin fmt = FMT_R; f3 = 3'd2; end
      6'd4:  begin fmt = FMT_R; f3 = 3'd3; end
      6'd5:  begin fmt = FMT_R; f3 = 3'd4; end
      6'd6:  begin fmt = FMT_R; f3 = 3'd5; end
      6'd7:  begin fmt = FMT_R; f3 = 3'd5; alt = 1'b1; end
      6'd8:  begin fmt = FMT_R; f3 = 3'd6; end
      6'd9:  begin fmt = FMT_R; f3 = 3'd7; end
      6'd10: begin fmt = FMT_I;  f3 = 3'd0; opc = OPC_OP_IMM; end
      6'd11: begin fmt = FMT_I;  f3 = 3'd2; opc = OPC_OP_IMM; end
      6'd12: begin fmt = FMT_I;  f3 = 3'd3; opc = OPC_OP_IMM; end
      6'd13: begin fmt = FMT_I;  f3 = 3'd4; opc = OPC_OP_IMM; end
      6'd14: begin fmt = FMT_I;  f3 = 3'd6; opc = OPC_OP_IMM; end
      6'd15: begin fmt = FMT_I;  f3 = 3'd7; opc = OPC_OP_IMM; end
      6'd16: begin fmt = FMT_SH; f3 = 3'd1; opc = OPC_OP_IMM; end
      6'd17: begin fmt = FMT_SH; f3 = 3'd5; opc = OPC_OP_IMM; end
      6'd18: begin fmt = FMT_SH; f3 = 3'd5; opc = OPC_OP_IMM; alt = 1'b1; end
      6'd19: begin fmt = FMT_I; f3 = 3'd0; opc = OPC_LOAD; end
      6'd20: begin fmt = FMT_I; f3 = 3'd1; opc = OPC_LOAD; end
      6'd21: begin fmt = FMT_I; f3 = 3'd2; opc = OPC_LOAD; end
      6'd22: begin fmt = FMT_I; f3 = 3'd4; opc = OPC_LOAD; end
      6'd23: begin fmt = FMT_I; f3 = 3'd5; opc = OPC_LOAD; end
      6'd24: begin fmt = FMT_S; f3 = 3'd0; opc = OPC_STORE; end
      6'd25: begin fmt = FMT_S; f3 = 3'd1; opc = OPC_STORE; end
      6'd26: begin fmt = FMT_S; f3 = 3'd2; opc = OPC_STORE; end
      6'd27: begin fmt = FMT_B; f3 = 3'd0; opc = OPC_BRANCH; end
      6'd28: begin fmt = FMT_B; f3 = 3'd1; opc = OPC_BRANCH; end
      6'd29: begin fmt = FMT_B; f3 = 3'd4; opc = OPC_BRANCH; end
      6'd30: begin fmt = FMT_B; f3 = 3'd5; opc = OPC_BRANCH; end
      6'd31: begin fmt = FMT_B; f3 = 3'd6; opc = OPC_BRANCH; end
      6'd32: begin fmt = FMT_B; f3 = 3'd7; opc = OPC_BRANCH; end
      6'd33: begin fmt = FMT_U; opc = OPC_LUI; end
      6'd34: begin fmt = FMT_U; opc = OPC_AUIPC; end
      6'd35: begin fmt = FMT_J; opc = OPC_JAL; end
      6'd36: begin fmt = FMT_I; f3 = 3'd0; opc = OPC_JALR; end
      6'd37: fmt = FMT_LI;
      6'd38: fmt = FMT_NOP;
      default: fmt = FMT_BAD;
    endcase
  end

  always_comb begin
    word0     = '0;
    word1     = '0;
    two_words = 1'b0;
    reject    = 1'b0;
    case (fmt)
      FMT_R:  word0 = {1'b0, alt, 5'd0, rs2, rs1, f3, rd, opc};
      FMT_I: begin
        reject = !fits12;
        word0  = {imm[11:0], rs1, f3, rd, opc};
      end
      FMT_SH: begin
        reject = !fits_sh;
        word0  = {1'b0, alt, 5'd0, imm[4:0], rs1, f3, rd, opc};
      end
      FMT_S: begin
        reject = !fits12;
        word0  = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
      end
      FMT_B: begin
        reject = !fits_b;
        word0  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
      end
      FMT_U:  word0 = {imm[19:0], rd, opc};
      FMT_J: begin
        reject = !fits_j;
        word0  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
      end
      FMT_LI: begin
        if (fits12) begin
          word0 = {imm[11:0], 5'd0, 3'd0, rd, OPC_OP_IMM};
        end else if (imm[11:0] == '0) begin
          word0 = {imm[31:12], rd, OPC_LUI};
        end else begin
          two_words = 1'b1;
          word0     = {li_hi, rd, OPC_LUI};
          word1     = {imm[11:0], rd, 3'd0, rd, OPC_OP_IMM};
        end
      end
      FMT_NOP: word0 = {12'd0, 5'd0, 3'd0, 5'd0, OPC_OP_IMM};
      default: reject = 1'b1;
    endcase
  end

  assign bus.in_ready = !out_valid_q || (bus.out_ready && out_last_q);
  assign fire         = bus.in_valid && bus.in_ready;
  assign accept       = fire && !reject;

  // A new accept overrides the handshake advance, which gives zero-bubble replacement.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_instr_q <= '0;
      pend_instr  <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q <= fire && reject;
      if (out_valid_q && bus.out_ready) begin
        if (state == EMIT2) begin
          out_instr_q <= pend_instr;
          out_last_q  <= 1'b1;
          state       <= EMIT1;
        end else begin
          out_valid_q <= 1'b0;
          state       <= IDLE;
        end
      end
      if (accept) begin
        out_valid_q <= 1'b1;
        out_instr_q <= word0;
        out_last_q  <= !two_words;
        pend_instr  <= word1;
        state       <= two_words ? EMIT2 : EMIT1;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_last  = out_last_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_rv32_instr_encoder.sv
// Directed self-checking bench for rv32_instr_encoder; inputs driven and outputs sampled on negedge.
module tb_rv32_instr_encoder;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rv32_instr_encoder_if bus ();

  rv32_instr_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_req(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] imm);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_rd    = rd;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_imm   = imm;
  endtask

  task automatic test_reset;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_rd     = '0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_imm    = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_instr !== 32'h0 || bus.out_last !== 1'b0 ||
        bus.err !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: valid=%b instr=%h last=%b err=%b rdy=%b, want 0 00000000 0 0 1",
               bus.out_valid, bus.out_instr, bus.out_last, bus.err, bus.in_ready);
    end
  endtask

  task automatic test_single_words;
    logic [5:0]  ops  [9] = '{6'd10, 6'd27, 6'd37, 6'd37, 6'd1, 6'd18, 6'd26, 6'd35, 6'd33};
    logic [4:0]  rds  [9] = '{5'd1, 5'd0, 5'd5, 5'd5, 5'd3, 5'd1, 5'd0, 5'd1, 5'd0};
    logic [4:0]  r1s  [9] = '{5'd2, 5'd1, 5'd0, 5'd0, 5'd1, 5'd2, 5'd2, 5'd0, 5'd0};
    logic [4:0]  r2s  [9] = '{5'd0, 5'd2, 5'd0, 5'd0, 5'd2, 5'd0, 5'd1, 5'd0, 5'd0};
    logic [31:0] imms [9] = '{32'hFFFFFFFF, 32'd8, 32'h00001000, 32'd7, 32'd0, 32'd3,
                              32'hFFFFFFFC, 32'd8, 32'hFFF80001};
    logic [31:0] exps [9] = '{32'hFFF10093, 32'h00208463, 32'h000012B7, 32'h00700293,
                              32'h402081B3, 32'h40315093, 32'hFE112E23, 32'h008000EF,
                              32'h80001037};
    for (int i = 0; i < 9; i++) begin
      drive_req(ops[i], rds[i], r1s[i], r2s[i], imms[i]);
      @(negedge clk);
      bus.in_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_instr !== exps[i] || bus.out_last !== 1'b1 ||
          bus.err !== 1'b0) begin
        errors++;
        $display("FAIL single[%0d]: valid=%b instr=%h last=%b err=%b, want 1 %h 1 0",
                 i, bus.out_valid, bus.out_instr, bus.out_last, bus.err, exps[i]);
      end
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL single_drain[%0d]: valid=%b want 0", i, bus.out_valid);
      end
    end
  endtask

  task automatic test_reject;
    logic [5:0]  ops  [5] = '{6'd27, 6'd10, 6'd40, 6'd16, 6'd35};
    logic [31:0] imms [5] = '{32'd3, 32'd2048, 32'd0, 32'd32, 32'h00100000};
    for (int i = 0; i < 5; i++) begin
      drive_req(ops[i], 5'd1, 5'd1, 5'd2, imms[i]);
      @(negedge clk);
      bus.in_valid = 1'b0;
      checks++;
      if (bus.err !== 1'b1 || bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reject[%0d]: err=%b valid=%b, want 1 0", i, bus.err, bus.out_valid);
      end
      @(negedge clk);
      checks++;
      if (bus.err !== 1'b0 || bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reject_pulse[%0d]: err=%b valid=%b, want 0 0", i, bus.err, bus.out_valid);
      end
    end
  endtask

  task automatic test_li_two_words;
    bus.out_ready = 1'b0;
    drive_req(6'd37, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h123462B7 || bus.out_last !== 1'b0 ||
          bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL li_hold[%0d]: valid=%b instr=%h last=%b rdy=%b, want 1 123462b7 0 0",
                 c, bus.out_valid, bus.out_instr, bus.out_last, bus.in_ready);
      end
      if (c < 3) @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'hFFF28293 || bus.out_last !== 1'b1) begin
      errors++;
      $display("FAIL li_second: valid=%b instr=%h last=%b, want 1 fff28293 1",
               bus.out_valid, bus.out_instr, bus.out_last);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL li_drain: valid=%b rdy=%b, want 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_back_to_back;
    int words;
    words = 0;
    bus.out_ready = 1'b1;
    drive_req(6'd38, 5'd0, 5'd0, 5'd0, 32'd0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 9) bus.in_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h00000013 || bus.out_last !== 1'b1) begin
        errors++;
        $display("FAIL nop[%0d]: valid=%b instr=%h last=%b, want 1 00000013 1",
                 c, bus.out_valid, bus.out_instr, bus.out_last);
      end else begin
        words++;
      end
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || words != 10) begin
      errors++;
      $display("FAIL nop_count: valid=%b words=%0d, want 0 10", bus.out_valid, words);
    end
  endtask

  task automatic test_reset_mid_li;
    bus.out_ready = 1'b0;
    drive_req(6'd37, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h123462B7) begin
      errors++;
      $display("FAIL rst_li_first: valid=%b instr=%h, want 1 123462b7", bus.out_valid, bus.out_instr);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_li: valid=%b rdy=%b, want 0 1", bus.out_valid, bus.in_ready);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_li_quiet[%0d]: valid=%b instr=%h, want 0", c, bus.out_valid, bus.out_instr);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_single_words;
    test_reject;
    test_li_two_words;
    test_back_to_back;
    test_reset_mid_li;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
